seq_det_param: RTL and testbench

Parametrised serial sequence detector, successor to the fixed 4-bit `0110` overlap detector FSMs. It samples one serial bit per enabled clock and compares a sliding history window against a SEQ_LEN-bit pattern. It supports both overlapping and non-overlapping detection, a runtime-loadable pattern, and an optional saturating match counter. It sits directly on a serial input stream, and its one-cycle `out` pulse feeds downstream control logic.

---
 rtl/seq_det_param.sv | 74 +++++++
 tb/tb_seq_det_param.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/seq_det_param.sv
// Parametrised serial sequence detector with overlap/non-overlap modes and a
// runtime-loadable pattern. Define SEQ_DET_MATCH_CNT_EN to build the saturating match counter.
module seq_det_param #(
  parameter int                 SEQ_LEN = 4,
  parameter logic [SEQ_LEN-1:0] PATTERN = 4'b0110,
  parameter int                 OVERLAP = 1,
  parameter int                 CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               in,
  input  logic               load,
  input  logic [SEQ_LEN-1:0] pat_in,
  output logic               out,
  output logic [CNT_W-1:0]   match_cnt
);

  localparam int FILL_W = $clog2(SEQ_LEN + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(SEQ_LEN);

  logic [SEQ_LEN-1:0] pat;
  logic [SEQ_LEN-1:0] hist;
  logic [FILL_W-1:0]  fill;

  logic [SEQ_LEN-1:0] hist_n;
  logic [FILL_W-1:0]  fill_n;
  logic               match;

  always_comb begin
    hist_n = {hist[SEQ_LEN-2:0], in};
    fill_n = (fill == FILL_FULL) ? fill : fill + FILL_W'(1);
    // The fill guard keeps the zeroed history from matching an all-zero pattern.
    match  = en && !load && (hist_n == pat) && (fill_n == FILL_FULL);
  end

  // NOTE: reset is synchronous here (sampled only at the clock edge), and all
  // state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      pat  <= PATTERN;
      hist <= '0;
      fill <= '0;
      out  <= 1'b0;
    end else if (load) begin
      pat  <= pat_in;
      hist <= '0;
      fill <= '0;
      out  <= 1'b0;
    end else if (en) begin
      hist <= hist_n;
      out  <= match;
      // Non-overlap mode discards the whole window after a hit.
      if (match && (OVERLAP == 0)) fill <= '0;
      else                         fill <= fill_n;
    end else begin
      out <= 1'b0;
    end
  end

`ifdef SEQ_DET_MATCH_CNT_EN
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || load)               cnt <= '0;
    else if (match && (cnt != '1)) cnt <= cnt + CNT_W'(1);
  end

  assign match_cnt = cnt;
`else
  assign match_cnt = '0;
`endif

endmodule

// File: tb/tb_seq_det_param.sv
// Directed bench for seq_det_param: a vector table shared by an overlap and a
// non-overlap instance, plus a hand-written saturation sequence on a third instance.
module tb_seq_det_param;

  logic       clk = 1'b0;
  logic       rst, en, in, load;
  logic [3:0] pat_in;

  logic       out_ov, out_nov, out_sat;
  logic [7:0] cnt_ov, cnt_nov;
  logic [1:0] cnt_sat;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  seq_det_param #(.SEQ_LEN(4), .PATTERN(4'b0110), .OVERLAP(1), .CNT_W(8)) u_ov (
    .clk(clk), .rst(rst), .en(en), .in(in), .load(load), .pat_in(pat_in),
    .out(out_ov), .match_cnt(cnt_ov));

  seq_det_param #(.SEQ_LEN(4), .PATTERN(4'b0110), .OVERLAP(0), .CNT_W(8)) u_nov (
    .clk(clk), .rst(rst), .en(en), .in(in), .load(load), .pat_in(pat_in),
    .out(out_nov), .match_cnt(cnt_nov));

  seq_det_param #(.SEQ_LEN(4), .PATTERN(4'b1111), .OVERLAP(1), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .en(en), .in(in), .load(load), .pat_in(pat_in),
    .out(out_sat), .match_cnt(cnt_sat));

  typedef struct {
    string      name;
    logic       rst, en, in, load;
    logic [3:0] pat_in;
    logic       eo_ov;
    int         ec_ov;
    logic       eo_nov;
    int         ec_nov;
  } vec_t;

  vec_t vecs[$];

  // Without the counter the port is tied low whatever the model count says.
  function automatic int cnt_exp(input int c);
`ifdef SEQ_DET_MATCH_CNT_EN
    return c;
`else
    return 0;
`endif
  endfunction

  task automatic check(input string name, input int actual, input int expected);
    total++;
    if (actual == expected) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  task automatic add(input string name, input logic r, input logic e, input logic i,
                     input logic l, input logic [3:0] p,
                     input logic eo_ov, input int ec_ov,
                     input logic eo_nov, input int ec_nov);
    vec_t v;
    v.name = name; v.rst = r; v.en = e; v.in = i; v.load = l; v.pat_in = p;
    v.eo_ov = eo_ov; v.ec_ov = ec_ov; v.eo_nov = eo_nov; v.ec_nov = ec_nov;
    vecs.push_back(v);
  endtask

  // Drive on the falling edge, sample 1 time unit after the rising edge.
  task automatic step(input logic r, input logic e, input logic i,
                      input logic l, input logic [3:0] p);
    @(negedge clk);
    rst = r; en = e; in = i; load = l; pat_in = p;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; in = 1'b0; load = 1'b0; pat_in = 4'h0;

    //   name        rst en in ld pat    ov_o ov_c nov_o nov_c
    add("reset",      1, 0, 0, 0, 4'h0,  0, 0,  0, 0);
    add("ovl_b1",     0, 1, 0, 0, 4'h0,  0, 0,  0, 0);
    add("ovl_b2",     0, 1, 1, 0, 4'h0,  0, 0,  0, 0);
    add("ovl_b3",     0, 1, 1, 0, 4'h0,  0, 0,  0, 0);
    add("ovl_b4",     0, 1, 0, 0, 4'h0,  1, 1,  1, 1);
    add("ovl_b5",     0, 1, 1, 0, 4'h0,  0, 1,  0, 1);
    add("ovl_b6",     0, 1, 1, 0, 4'h0,  0, 1,  0, 1);
    add("ovl_b7",     0, 1, 0, 0, 4'h0,  1, 2,  0, 1);
    add("idle",       0, 0, 0, 0, 4'h0,  0, 2,  0, 1);
    // load outranks en; the in=1 on this edge must be ignored
    add("load_1001",  0, 1, 1, 1, 4'h9,  0, 0,  0, 0);
    add("ld_b1",      0, 1, 1, 0, 4'h0,  0, 0,  0, 0);
    add("ld_b2",      0, 1, 0, 0, 4'h0,  0, 0,  0, 0);
    add("ld_b3",      0, 1, 0, 0, 4'h0,  0, 0,  0, 0);
    add("ld_b4",      0, 1, 1, 0, 4'h0,  1, 1,  1, 1);
    add("old_b1",     0, 1, 0, 0, 4'h0,  0, 1,  0, 1);
    add("old_b2",     0, 1, 1, 0, 4'h0,  0, 1,  0, 1);
    add("old_b3",     0, 1, 1, 0, 4'h0,  0, 1,  0, 1);
    add("old_b4",     0, 1, 0, 0, 4'h0,  0, 1,  0, 1);
    // enable gap: 0,1, two idle cycles with in=1, then 1,0
    add("gap_rst",    1, 0, 0, 0, 4'h0,  0, 0,  0, 0);
    add("gap_b1",     0, 1, 0, 0, 4'h0,  0, 0,  0, 0);
    add("gap_b2",     0, 1, 1, 0, 4'h0,  0, 0,  0, 0);
    add("gap_i1",     0, 0, 1, 0, 4'h0,  0, 0,  0, 0);
    add("gap_i2",     0, 0, 1, 0, 4'h0,  0, 0,  0, 0);
    add("gap_b3",     0, 1, 1, 0, 4'h0,  0, 0,  0, 0);
    add("gap_b4",     0, 1, 0, 0, 4'h0,  1, 1,  1, 1);
    // fill guard with an all-zero pattern
    add("load_0000",  0, 0, 0, 1, 4'h0,  0, 0,  0, 0);
    add("z_b1",       0, 1, 0, 0, 4'h0,  0, 0,  0, 0);
    add("z_b2",       0, 1, 0, 0, 4'h0,  0, 0,  0, 0);
    add("z_b3",       0, 1, 0, 0, 4'h0,  0, 0,  0, 0);
    add("z_b4",       0, 1, 0, 0, 4'h0,  1, 1,  1, 1);
    add("z_b5",       0, 1, 0, 0, 4'h0,  1, 2,  0, 1);
    // reset mid-sequence: 0,1,1, reset (pattern back to 0110), then 0
    add("mid_rst0",   1, 0, 0, 0, 4'h0,  0, 0,  0, 0);
    add("mid_b1",     0, 1, 0, 0, 4'h0,  0, 0,  0, 0);
    add("mid_b2",     0, 1, 1, 0, 4'h0,  0, 0,  0, 0);
    add("mid_b3",     0, 1, 1, 0, 4'h0,  0, 0,  0, 0);
    add("mid_rst",    1, 1, 0, 0, 4'h0,  0, 0,  0, 0);
    add("mid_b4",     0, 1, 0, 0, 4'h0,  0, 0,  0, 0);

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].en, vecs[i].in, vecs[i].load, vecs[i].pat_in);
      check($sformatf("%s out_ov", vecs[i].name),  int'(out_ov),  int'(vecs[i].eo_ov));
      check($sformatf("%s cnt_ov", vecs[i].name),  int'(cnt_ov),  cnt_exp(vecs[i].ec_ov));
      check($sformatf("%s out_nov", vecs[i].name), int'(out_nov), int'(vecs[i].eo_nov));
      check($sformatf("%s cnt_nov", vecs[i].name), int'(cnt_nov), cnt_exp(vecs[i].ec_nov));
    end

    // Saturation: pattern 1111, overlap, 2-bit counter, eight 1s after reset.
    step(1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
    check("sat reset out", int'(out_sat), 0);
    check("sat reset cnt", int'(cnt_sat), 0);
    for (int k = 1; k <= 8; k++) begin
      step(1'b0, 1'b1, 1'b1, 1'b0, 4'h0);
      check($sformatf("sat b%0d out", k), int'(out_sat), (k >= 4) ? 1 : 0);
      check($sformatf("sat b%0d cnt", k), int'(cnt_sat),
            cnt_exp((k < 4) ? 0 : ((k - 3 > 3) ? 3 : k - 3)));
    end
    step(1'b0, 1'b0, 1'b1, 1'b0, 4'h0);
    check("sat idle out", int'(out_sat), 0);
    check("sat idle cnt", int'(cnt_sat), cnt_exp(3));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1);
  end

endmodule
